sorted_serializer: RTL and testbench



---
 rtl/sorted_serializer_pkg.sv | 18 +
 rtl/sorted_serializer.sv | 180 ++++++++++++++++++
 tb/tb_sorted_serializer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sorted_serializer_pkg.sv
// sorted_serializer_pkg
// Shared definitions for the sorted_serializer output stage: the two-state
// FSM encoding, the frame length (eight words per frame) and the width of
// the in-frame word index.
package sorted_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int FRAME_LEN = 8;
  localparam int IDX_W     = 3;

  localparam logic [IDX_W-1:0] FIRST_IDX = 3'd0;
  localparam logic [IDX_W-1:0] LAST_IDX  = 3'd7;

endpackage

// File: rtl/sorted_serializer.sv
// sorted_serializer
// Captures the eight sorted words y1..y8 from the sorting network in a single
// valid/ready handshake and streams them out one word per beat with a
// last-beat marker, an in-frame index and a running count of completed frames.
// A new frame may be accepted on the final beat of the current one, giving an
// eight-cycle frame period with no idle cycle.
//
// Ports:
//   clk, rst_n          single clock, asynchronous active-low reset
//   in_valid/in_ready   input frame handshake (in_ready is combinational
//                       from out_ready so frames can chain back-to-back)
//   y1..y8              sorted words, y1 is position 1
//   out_data/out_valid/out_ready/out_last/out_index
//                       serial stream; all out_* driven from registers
//   frame_count         frames fully emitted, wraps modulo 2^16
//
// Build option: SORTED_SERIALIZER_DESCEND_EN -- when defined the words are
// emitted y8 first through y1 last; otherwise y1 first through y8 last.
module sorted_serializer
  import sorted_serializer_pkg::*;
#(
  parameter int Size = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [Size-1:0] y1,
  input  logic [Size-1:0] y2,
  input  logic [Size-1:0] y3,
  input  logic [Size-1:0] y4,
  input  logic [Size-1:0] y5,
  input  logic [Size-1:0] y6,
  input  logic [Size-1:0] y7,
  input  logic [Size-1:0] y8,
  output logic [Size-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic [2:0]      out_index,
  output logic [15:0]     frame_count
);

  state_t            state_r, state_nxt_s;
  logic [IDX_W-1:0]  idx_r, idx_nxt_s, idx_inc_s;
  logic [Size-1:0]   bank_r  [FRAME_LEN];
  logic [Size-1:0]   frame_s [FRAME_LEN];
  logic [Size-1:0]   data_nxt_s;
  logic              beat_s, last_beat_s, accept_s, in_ready_s;
  logic [Size-1:0]   out_data_r;
  logic              out_valid_r, out_last_r;
  logic [IDX_W-1:0]  out_index_r;
  logic [15:0]       frame_count_r;

  // The bank is stored in emission order, so the read side is the same
  // for both builds and bank[idx] is always the word for beat idx.
`ifdef SORTED_SERIALIZER_DESCEND_EN
  assign frame_s[0] = y8;
  assign frame_s[1] = y7;
  assign frame_s[2] = y6;
  assign frame_s[3] = y5;
  assign frame_s[4] = y4;
  assign frame_s[5] = y3;
  assign frame_s[6] = y2;
  assign frame_s[7] = y1;
`else
  assign frame_s[0] = y1;
  assign frame_s[1] = y2;
  assign frame_s[2] = y3;
  assign frame_s[3] = y4;
  assign frame_s[4] = y5;
  assign frame_s[5] = y6;
  assign frame_s[6] = y7;
  assign frame_s[7] = y8;
`endif

  // Handshake decode: a beat completes whenever SEND meets out_ready, and a
  // frame may be taken in IDLE or on the completing final beat.
  always_comb begin
    beat_s      = (state_r == SEND) && out_ready;
    last_beat_s = beat_s && (idx_r == LAST_IDX);
    in_ready_s  = (state_r == IDLE) || last_beat_s;
    accept_s    = in_valid && in_ready_s;
    idx_inc_s   = idx_r + 3'd1;
  end

  // Next-state, next-index and next output word; out_* are registered from
  // these so the first word appears right after the accepting edge.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    data_nxt_s  = out_data_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = SEND;
          idx_nxt_s   = FIRST_IDX;
          data_nxt_s  = frame_s[0];
        end else begin
          state_nxt_s = IDLE;
          idx_nxt_s   = FIRST_IDX;
          data_nxt_s  = '0;
        end
      end
      SEND: begin
        if (accept_s) begin
          // Chained frame: reload on the final beat and keep streaming.
          state_nxt_s = SEND;
          idx_nxt_s   = FIRST_IDX;
          data_nxt_s  = frame_s[0];
        end else if (last_beat_s) begin
          state_nxt_s = IDLE;
          idx_nxt_s   = FIRST_IDX;
          data_nxt_s  = '0;
        end else if (beat_s) begin
          idx_nxt_s  = idx_inc_s;
          data_nxt_s = bank_r[idx_inc_s];
        end else begin
          // Stall: everything holds.
          idx_nxt_s  = idx_r;
          data_nxt_s = out_data_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        idx_nxt_s   = FIRST_IDX;
        data_nxt_s  = '0;
      end
    endcase
  end

  // FSM state, index and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= FIRST_IDX;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      out_index_r <= FIRST_IDX;
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      out_valid_r <= (state_nxt_s == SEND);
      out_data_r  <= data_nxt_s;
      out_last_r  <= (state_nxt_s == SEND) && (idx_nxt_s == LAST_IDX);
      out_index_r <= idx_nxt_s;
    end
  end

  // Word bank: written only on an accepted input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        bank_r[i] <= '0;
      end
    end else if (accept_s) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        bank_r[i] <= frame_s[i];
      end
    end
  end

  // Completed-frame counter; wraps silently at 2^16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count_r <= 16'd0;
    end else if (last_beat_s) begin
      frame_count_r <= frame_count_r + 16'd1;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_data    = out_data_r;
  assign out_valid   = out_valid_r;
  assign out_last    = out_last_r;
  assign out_index   = out_index_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_sorted_serializer.sv
// tb_sorted_serializer
// Self-checking bench for sorted_serializer. A queue-based reference model
// tracks the words still owed to the consumer; every cycle the DUT outputs
// are compared with it. Table vectors cover the fixed frames, hand-written
// sequences cover chaining, mid-frame reset and counter wrap, and a random
// phase exercises arbitrary valid/ready traffic.
module tb_sorted_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  y [8];
  logic        in_ready, out_valid, out_last;
  logic [7:0]  out_data;
  logic [2:0]  out_index;
  logic [15:0] frame_count;

  sorted_serializer #(.Size(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .y1(y[0]), .y2(y[1]), .y3(y[2]), .y4(y[3]),
    .y5(y[4]), .y6(y[5]), .y7(y[6]), .y8(y[7]),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_index(out_index), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0]  q [$];
  logic [7:0]  got [$];
  int          beat_cnt = 0;
  logic [15:0] fc_m = 16'd0;

  typedef struct {
    logic [7:0]  y   [8];
    logic [7:0]  exp [8];   // ascending emission order
    logic [15:0] rdy;       // out_ready pattern, bit k used on cycle k%16
  } vec_t;
  vec_t tbl [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] emit_word(input int i);
`ifdef SORTED_SERIALIZER_DESCEND_EN
    return y[7-i];
`else
    return y[i];
`endif
  endfunction

  // One clock cycle: entered at posedge+1 with inputs driven; checks and
  // advances the model, then returns at the next posedge+1.
  task automatic cycle(output bit acc);
    bit m_valid, m_ready, ohs;
    #1;
    m_valid = (q.size() > 0);
    m_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("in_ready", 32'(in_ready), 32'(m_ready));
    chk("frame_count", 32'(frame_count), 32'(fc_m));
    if (m_valid) begin
      chk("out_data", 32'(out_data), 32'(q[0]));
      chk("out_index", 32'(out_index), 32'(beat_cnt % 8));
      chk("out_last", 32'(out_last), 32'((beat_cnt % 8) == 7));
    end
    ohs = m_valid && out_ready;
    acc = in_valid && m_ready;
    if (ohs) begin
      got.push_back(out_data);
      void'(q.pop_front());
      beat_cnt++;
      if (beat_cnt % 8 == 0) fc_m = fc_m + 16'd1;
    end
    if (acc) begin
      for (int i = 0; i < 8; i++) q.push_back(emit_word(i));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    q.delete();
    got.delete();
    beat_cnt = 0;
    fc_m = 16'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", 32'(out_data), 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    chk("rst out_index", 32'(out_index), 32'd0);
    chk("rst frame_count", 32'(frame_count), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Present the current y until accepted, with a bounded wait.
  task automatic send_frame();
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    while (!acc && n < 50) begin
      cycle(acc);
      n++;
    end
    if (!acc) chk("accept timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input logic [15:0] pat);
    bit acc;
    int k;
    k = 0;
    while (q.size() > 0 && k < 200) begin
      out_ready = pat[k % 16];
      y[k % 8] = 8'($urandom);   // bank must ignore y outside a handshake
      cycle(acc);
      k++;
    end
    if (q.size() > 0) chk("drain timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    bit acc;
    logic [7:0] e;
    int vcnt;

    for (int i = 0; i < 8; i++) y[i] = 8'd0;
    tbl[0].y   = '{8'd3, 8'd7, 8'd12, 8'd20, 8'd41, 8'd90, 8'd150, 8'd255};
    tbl[0].exp = '{8'd3, 8'd7, 8'd12, 8'd20, 8'd41, 8'd90, 8'd150, 8'd255};
    tbl[0].rdy = 16'hFFFF;
    tbl[1].y   = '{8'd3, 8'd7, 8'd12, 8'd20, 8'd41, 8'd90, 8'd150, 8'd255};
    tbl[1].exp = '{8'd3, 8'd7, 8'd12, 8'd20, 8'd41, 8'd90, 8'd150, 8'd255};
    tbl[1].rdy = 16'h9999;     // 1,0,0,1,...
    tbl[2].y   = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    tbl[2].exp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    tbl[2].rdy = 16'hA5C3;

    @(posedge clk);
    #1;
    do_reset();
    // Reset then idle
    cycle(acc);
    cycle(acc);

    // Table vectors: one frame each, compared word by word afterwards
    for (int v = 0; v < 3; v++) begin
      do_reset();
      for (int i = 0; i < 8; i++) y[i] = tbl[v].y[i];
      send_frame();
      drain(tbl[v].rdy);
      chk("frame_len", 32'(got.size()), 32'd8);
      for (int i = 0; i < 8 && i < got.size(); i++) begin
`ifdef SORTED_SERIALIZER_DESCEND_EN
        e = tbl[v].exp[7-i];
`else
        e = tbl[v].exp[i];
`endif
        chk("frame_word", 32'(got[i]), 32'(e));
      end
      out_ready = 1'b0;
      cycle(acc);
      chk("frame_count_1", 32'(frame_count), 32'd1);
    end

    // Back-to-back: second frame offered during the final beat of the first
    do_reset();
    for (int i = 0; i < 8; i++) y[i] = tbl[0].y[i];
    out_ready = 1'b1;
    in_valid = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) cycle(acc);
    for (int i = 0; i < 8; i++) y[i] = 8'(i);
    in_valid = 1'b1;
    cycle(acc);
    chk("b2b accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      vcnt += int'(out_valid);
      cycle(acc);
    end
    chk("b2b no gap", 32'(vcnt), 32'd8);
    chk("b2b beats", 32'(got.size()), 32'd16);
    cycle(acc);
    chk("b2b frame_count", 32'(frame_count), 32'd2);

    // Mid-frame reset after three beats
    do_reset();
    for (int i = 0; i < 8; i++) y[i] = tbl[0].y[i];
    out_ready = 1'b1;
    send_frame();
    for (int i = 0; i < 3; i++) cycle(acc);
    do_reset();
    cycle(acc);
    chk("post-abort frame_count", 32'(frame_count), 32'd0);

    // Counter wrap from 0xFFFF
    do_reset();
    force dut.frame_count_r = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.frame_count_r;
    fc_m = 16'hFFFF;
    cycle(acc);
    for (int i = 0; i < 8; i++) y[i] = tbl[0].y[i];
    out_ready = 1'b1;
    send_frame();
    drain(16'hFFFF);
    cycle(acc);
    chk("wrap frame_count", 32'(frame_count), 32'd0);

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      in_valid = 1'($urandom % 2);
      out_ready = ($urandom % 4) != 0;
      for (int i = 0; i < 8; i++) y[i] = 8'($urandom);
      cycle(acc);
    end
    in_valid = 1'b0;
    drain(16'hFFFF);
    out_ready = 1'b0;
    cycle(acc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
